// File: rtl/stack_arb_pkg.sv
// Shared types for the stack arbiter: FSM state encoding and push/pop op codes.
package stack_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic OP_PUSH = 1'b1;
    localparam logic OP_POP  = 1'b0;

endpackage

// File: rtl/stack_arb_grant.sv
// Combinational one-hot grant picker. With STACK_ARB_RR_EN defined the search
// starts after ptr (round-robin); otherwise the lowest requesting index wins.
module stack_arb_grant #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant
);

    logic found_s;

`ifdef STACK_ARB_RR_EN
    logic [IDW-1:0] idx_s;

    // Rotating search beginning at (ptr + 1) mod NREQ; first valid requester wins.
    always_comb begin
        grant   = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx_s = IDW'((int'(ptr) + k) % NREQ);
            if (!found_s && req_valid[idx_s]) begin
                grant[idx_s] = 1'b1;
                found_s      = 1'b1;
            end else begin
            end
        end
    end
`else
    logic unused_ptr_s;
    assign unused_ptr_s = ^ptr;

    // Fixed priority: lowest valid index wins.
    always_comb begin
        grant   = '0;
        found_s = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found_s && req_valid[k]) begin
                grant[k] = 1'b1;
                found_s  = 1'b1;
            end else begin
            end
        end
    end
`endif

endmodule

// File: rtl/stack_arbiter.sv
// Shares one LIFO stack between NREQ requesters, one push/pop at a time, with
// overflow/underflow rejection. Define STACK_ARB_RR_EN for round-robin arbitration.
module stack_arbiter
    import stack_arb_pkg::*;
#(
    parameter int WORD  = 16,
    parameter int DEPTH = 1024,
    parameter int NREQ  = 2,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_op,
    input  logic [NREQ*WORD-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 resp_valid,
    output logic [IDW-1:0]       resp_id,
    output logic [WORD-1:0]      resp_data,
    output logic                 resp_err,
    output logic                 stk_push,
    output logic                 stk_pop,
    output logic [WORD-1:0]      stk_data_i,
    input  logic [WORD-1:0]      stk_data_o,
    output logic [CW-1:0]        level,
    output logic                 is_full,
    output logic                 is_empty
);

    state_t          state_r, state_nxt_s;
    logic [NREQ-1:0] grant_s;
    logic [IDW-1:0]  ptr_s;
    logic            hs_s;
    logic [IDW-1:0]  hs_id_s;
    logic            hs_op_s;
    logic [WORD-1:0] hs_data_s;
    logic            hs_err_s;

    logic            op_r;
    logic [CW-1:0]   level_r, level_nxt_s;
    logic            full_r, empty_r;
    logic            push_nxt_s, pop_nxt_s, resp_nxt_s;
    logic            stk_push_r, stk_pop_r, resp_valid_r, resp_err_r;
    logic [WORD-1:0] stk_data_r, resp_data_r;
    logic [IDW-1:0]  resp_id_r;

    stack_arb_grant #(.NREQ(NREQ), .IDW(IDW)) u_grant (
        .req_valid (req_valid),
        .ptr       (ptr_s),
        .grant     (grant_s)
    );

`ifdef STACK_ARB_RR_EN
    logic [IDW-1:0] ptr_r;

    // Round-robin pointer remembers the last granted requester.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_r <= IDW'(NREQ - 1);
        end else if (hs_s) begin
            ptr_r <= hs_id_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end
    assign ptr_s = ptr_r;
`else
    assign ptr_s = '0;
`endif

    assign req_ready = (state_r == IDLE) ? grant_s : '0;
    assign hs_s      = |(req_valid & req_ready);
    assign hs_op_s   = req_op[hs_id_s];
    assign hs_data_s = req_data[hs_id_s*WORD +: WORD];
    // A rejected operation never strobes the stack, so level cannot wrap.
    assign hs_err_s  = (hs_op_s == OP_PUSH) ? full_r : empty_r;

    // Encode the one-hot grant into a requester index.
    always_comb begin
        hs_id_s = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_s[k]) begin
                hs_id_s = IDW'(k);
            end else begin
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (hs_s) begin
                    state_nxt_s = hs_err_s ? RESP : ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE:   state_nxt_s = (op_r == OP_PUSH) ? RESP : WAIT;
            WAIT:    state_nxt_s = RESP;
            RESP:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs: next values of the registered strobes, response pulse and level.
    always_comb begin
        push_nxt_s  = 1'b0;
        pop_nxt_s   = 1'b0;
        level_nxt_s = level_r;
        if (hs_s && !hs_err_s) begin
            push_nxt_s = (hs_op_s == OP_PUSH);
            pop_nxt_s  = (hs_op_s == OP_POP);
        end else begin
        end
        if (state_r == ISSUE) begin
            if (op_r == OP_PUSH) begin
                level_nxt_s = level_r + CW'(1);
            end else begin
                level_nxt_s = level_r - CW'(1);
            end
        end else begin
        end
        resp_nxt_s = (state_nxt_s == RESP);
    end

    // Datapath registers: latched request, stack strobes, occupancy and response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_r         <= OP_POP;
            stk_push_r   <= 1'b0;
            stk_pop_r    <= 1'b0;
            stk_data_r   <= '0;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_id_r    <= '0;
            resp_data_r  <= '0;
            level_r      <= '0;
            full_r       <= 1'b0;
            empty_r      <= 1'b1;
        end else begin
            stk_push_r   <= push_nxt_s;
            stk_pop_r    <= pop_nxt_s;
            resp_valid_r <= resp_nxt_s;
            level_r      <= level_nxt_s;
            full_r       <= (level_nxt_s == CW'(DEPTH));
            empty_r      <= (level_nxt_s == '0);
            if (hs_s) begin
                op_r        <= hs_op_s;
                resp_id_r   <= hs_id_s;
                resp_err_r  <= hs_err_s;
                resp_data_r <= '0;
                if (push_nxt_s) begin
                    stk_data_r <= hs_data_s;
                end else begin
                    stk_data_r <= stk_data_r;
                end
            end else if (state_r == WAIT) begin
                resp_data_r <= stk_data_o;
            end else begin
            end
        end
    end

    assign stk_push   = stk_push_r;
    assign stk_pop    = stk_pop_r;
    assign stk_data_i = stk_data_r;
    assign resp_valid = resp_valid_r;
    assign resp_err   = resp_err_r;
    assign resp_id    = resp_id_r;
    assign resp_data  = resp_data_r;
    assign level      = level_r;
    assign is_full    = full_r;
    assign is_empty   = empty_r;

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed self-checking bench for stack_arbiter (DEPTH=4, NREQ=2) with a small
// behavioural LIFO attached to the stack port.
module tb_stack_arbiter;

    localparam int WORD  = 16;
    localparam int DEPTH = 4;
    localparam int NREQ  = 2;
    localparam int IDW   = 1;
    localparam int CW    = 3;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_op;
    logic [NREQ*WORD-1:0] req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 resp_valid;
    logic [IDW-1:0]       resp_id;
    logic [WORD-1:0]      resp_data;
    logic                 resp_err;
    logic                 stk_push;
    logic                 stk_pop;
    logic [WORD-1:0]      stk_data_i;
    logic [WORD-1:0]      stk_data_o;
    logic [CW-1:0]        level;
    logic                 is_full;
    logic                 is_empty;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    stack_arbiter #(.WORD(WORD), .DEPTH(DEPTH), .NREQ(NREQ)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .stk_push   (stk_push),
        .stk_pop    (stk_pop),
        .stk_data_i (stk_data_i),
        .stk_data_o (stk_data_o),
        .level      (level),
        .is_full    (is_full),
        .is_empty   (is_empty)
    );

    // Behavioural LIFO sharing the arbiter's reset; popped word appears next cycle.
    logic [WORD-1:0] mem [0:7];
    logic [2:0]      sp;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp         <= 3'd0;
            stk_data_o <= '0;
        end else if (stk_push) begin
            mem[sp] <= stk_data_i;
            sp      <= sp + 3'd1;
        end else if (stk_pop) begin
            stk_data_o <= mem[sp - 3'd1];
            sp         <= sp - 3'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a single request at a negedge, check its grant, drop it after the handshake edge.
    task automatic req_one(input int id, input logic op, input logic [WORD-1:0] d);
        req_valid = '0;
        req_op    = '0;
        req_data  = '0;
        req_valid[id] = 1'b1;
        req_op[id]    = op;
        req_data[id*WORD +: WORD] = d;
        #1;
        chk("ready", 32'(req_ready), 32'(1 << id));
        @(negedge clk);
        req_valid = '0;
    endtask

    logic [NREQ-1:0] gnt [0:3];
    int ng;
    int cyc;

    initial begin
        req_valid = '0;
        req_op    = '0;
        req_data  = '0;
        repeat (2) @(negedge clk);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_empty", 32'(is_empty), 32'd1);
        chk("rst_full", 32'(is_full), 32'd0);
        chk("rst_rv", 32'(resp_valid), 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        chk("rst_id", 32'(resp_id), 32'd0);
        chk("rst_data", 32'(resp_data), 32'd0);
        chk("rst_push", 32'(stk_push), 32'd0);
        chk("rst_pop", 32'(stk_pop), 32'd0);
        chk("rst_sdi", 32'(stk_data_i), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Requester 0 pushes 0x1234.
        req_one(0, 1'b1, 16'h1234);
        chk("t1_push", 32'(stk_push), 32'd1);
        chk("t1_sdi", 32'(stk_data_i), 32'h1234);
        chk("t1_nopop", 32'(stk_pop), 32'd0);
        chk("t1_rv_c1", 32'(resp_valid), 32'd0);
        @(negedge clk);
        chk("t1_rv", 32'(resp_valid), 32'd1);
        chk("t1_id", 32'(resp_id), 32'd0);
        chk("t1_err", 32'(resp_err), 32'd0);
        chk("t1_data", 32'(resp_data), 32'd0);
        chk("t1_level", 32'(level), 32'd1);
        chk("t1_empty", 32'(is_empty), 32'd0);
        chk("t1_push_c2", 32'(stk_push), 32'd0);
        @(negedge clk);

        // Requester 1 pops it back.
        req_one(1, 1'b0, 16'h0000);
        chk("t2_pop", 32'(stk_pop), 32'd1);
        chk("t2_nopush", 32'(stk_push), 32'd0);
        @(negedge clk);
        chk("t2_rv_wait", 32'(resp_valid), 32'd0);
        chk("t2_pop_c2", 32'(stk_pop), 32'd0);
        chk("t2_level_wait", 32'(level), 32'd0);
        @(negedge clk);
        chk("t2_rv", 32'(resp_valid), 32'd1);
        chk("t2_id", 32'(resp_id), 32'd1);
        chk("t2_data", 32'(resp_data), 32'h1234);
        chk("t2_err", 32'(resp_err), 32'd0);
        chk("t2_empty", 32'(is_empty), 32'd1);
        @(negedge clk);

        // Pop from an empty stack is rejected in one cycle.
        req_one(0, 1'b0, 16'h0000);
        chk("t3_rv", 32'(resp_valid), 32'd1);
        chk("t3_err", 32'(resp_err), 32'd1);
        chk("t3_data", 32'(resp_data), 32'd0);
        chk("t3_pop", 32'(stk_pop), 32'd0);
        chk("t3_level", 32'(level), 32'd0);
        @(negedge clk);
        chk("t3_rv_off", 32'(resp_valid), 32'd0);

        // Fill to DEPTH, then the fifth push overflows.
        for (int i = 0; i < 4; i++) begin
            req_one(0, 1'b1, 16'(16'hA000 + i));
            chk("t4_push", 32'(stk_push), 32'd1);
            @(negedge clk);
            chk("t4_rv", 32'(resp_valid), 32'd1);
            chk("t4_err", 32'(resp_err), 32'd0);
            @(negedge clk);
        end
        chk("t4_level", 32'(level), 32'd4);
        chk("t4_full", 32'(is_full), 32'd1);
        req_one(1, 1'b1, 16'hBEEF);
        chk("t4_ovf_push", 32'(stk_push), 32'd0);
        chk("t4_ovf_rv", 32'(resp_valid), 32'd1);
        chk("t4_ovf_err", 32'(resp_err), 32'd1);
        chk("t4_ovf_id", 32'(resp_id), 32'd1);
        chk("t4_ovf_level", 32'(level), 32'd4);
        chk("t4_ovf_full", 32'(is_full), 32'd1);
        @(negedge clk);

        // Clear, then both requesters push continuously.
        reset = 1'b0;
        @(negedge clk);
        chk("t5_rst_level", 32'(level), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        req_valid = 2'b11;
        req_op    = 2'b11;
        req_data  = {16'h2222, 16'h1111};
        for (int i = 0; i < 4; i++) gnt[i] = '0;
        ng  = 0;
        cyc = 0;
        while (ng < 4 && cyc < 40) begin
            #1;
            if (req_ready != '0) begin
                gnt[ng] = req_ready;
                ng++;
            end
            @(negedge clk);
            cyc++;
        end
        req_valid = '0;
        chk("t5_grants", 32'(ng), 32'd4);
        for (int i = 0; i < 4; i++) begin
`ifdef STACK_ARB_RR_EN
            chk("t5_rr_gnt", 32'(gnt[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
`else
            chk("t5_pri_gnt", 32'(gnt[i]), 32'd1);
`endif
        end
        @(negedge clk);
        chk("t5_level", 32'(level), 32'd4);
        @(negedge clk);

        // Reset asserted during the WAIT of a pop.
        req_one(1, 1'b0, 16'h0000);
        chk("t6_pop", 32'(stk_pop), 32'd1);
        @(negedge clk);
        chk("t6_level_wait", 32'(level), 32'd3);
        reset = 1'b0;
        @(negedge clk);
        chk("t6_level", 32'(level), 32'd0);
        chk("t6_empty", 32'(is_empty), 32'd1);
        chk("t6_rv", 32'(resp_valid), 32'd0);
        chk("t6_pop_off", 32'(stk_pop), 32'd0);
        chk("t6_push_off", 32'(stk_push), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_rv_after", 32'(resp_valid), 32'd0);
        chk("t6_ready_idle", 32'(req_ready), 32'd0);
        req_one(0, 1'b0, 16'h0000);
        chk("t6_empty_err", 32'(resp_err), 32'd1);
        chk("t6_empty_rv", 32'(resp_valid), 32'd1);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
